// File: rtl/jump_control_unit_p.sv
// jump_control_unit_p: registered branch / call / return / interrupt redirect
// unit for a pipelined core. Decides at each rising edge whether the next PC
// comes from jmp_loc, and keeps a small return-address stack shared by
// subroutine calls and interrupt entry.
//
// Build option: define JCU_CALL_RET_EN to decode CALL and RET. Without it those
// opcodes behave as NOP and the stack is used only by interrupt entry and RETI.
module jump_control_unit_p #(
  parameter int                ADDR_W    = 8,
  parameter int                INS_W     = 20,
  parameter int                STK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] ISR_VEC   = ADDR_W'('hF0)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INS_W-1:0]  ins,
  input  logic              interrupt,
  input  logic [ADDR_W-1:0] current_address,
  input  logic [3:0]        flag_ex,
  output logic              pc_mux_sel,
  output logic [ADDR_W-1:0] jmp_loc,
  output logic              int_ack,
  output logic              stk_err
);

  // Stack pointer carries one extra bit so "full" (count == STK_DEPTH) is
  // distinguishable from "empty" without wrapping.
  localparam int PTR_W = $clog2(STK_DEPTH);
  localparam int SP_W  = PTR_W + 1;

  localparam logic [4:0] OP_JMP  = 5'b11000;
  localparam logic [4:0] OP_JZ   = 5'b11100;
  localparam logic [4:0] OP_JNZ  = 5'b11101;
  localparam logic [4:0] OP_JC   = 5'b11110;
  localparam logic [4:0] OP_JNC  = 5'b11111;
  localparam logic [4:0] OP_CALL = 5'b11010;
  localparam logic [4:0] OP_RET  = 5'b11011;
  localparam logic [4:0] OP_RETI = 5'b10000;

  // RUN decides normally; SHADOW is the one cycle after a redirect, during
  // which the instruction in execute is the wrong-path one and is squashed.
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } state_e;

  state_e state, next_state;

  logic              ie, ie_next;
  logic [SP_W-1:0]   sp;
  logic [ADDR_W-1:0] stack_mem [STK_DEPTH];

  logic              sel_next;
  logic [ADDR_W-1:0] loc_next;
  logic              ack_next;
  logic              err_set;
  logic              push_req;
  logic              pop_req;
  logic [ADDR_W-1:0] push_data;
  logic              do_push;
  logic              do_pop;

  logic [4:0]        opcode;
  logic [ADDR_W-1:0] target;
  logic              flag_z;
  logic              flag_c;
  logic              stk_full;
  logic              stk_empty;
  logic [PTR_W-1:0]  top_idx;
  logic [ADDR_W-1:0] stack_top;
  logic              unused_bits;

  assign opcode    = ins[INS_W-1:INS_W-5];
  assign target    = ins[ADDR_W-1:0];
  assign flag_z    = flag_ex[3];
  assign flag_c    = flag_ex[2];
  assign stk_full  = (sp == SP_W'(STK_DEPTH));
  assign stk_empty = (sp == '0);
  assign top_idx   = sp[PTR_W-1:0] - 1'b1;
  assign stack_top = stack_mem[top_idx];

  // Middle instruction bits and the V/N flags play no part in control flow.
  assign unused_bits = ^{ins, flag_ex[1:0]};

  // Overflowing pushes and underflowing pops leave the stack untouched; the
  // request itself still reaches err_set below.
  assign do_push = push_req && !stk_full;
  assign do_pop  = pop_req && !stk_empty;

  // Next-state and redirect decision; interrupt beats the instruction in RUN.
  // NOTE: every output of this block gets a default first so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    next_state = state;
    sel_next   = 1'b0;
    loc_next   = jmp_loc;
    ack_next   = 1'b0;
    ie_next    = ie;
    err_set    = 1'b0;
    push_req   = 1'b0;
    pop_req    = 1'b0;
    push_data  = current_address;

    unique case (state)
      ST_RUN: begin
        if (interrupt && ie) begin
          // The instruction at current_address has not executed; resume there.
          push_req   = 1'b1;
          push_data  = current_address;
          err_set    = stk_full;
          sel_next   = 1'b1;
          loc_next   = ISR_VEC;
          ack_next   = 1'b1;
          ie_next    = 1'b0;
          next_state = ST_SHADOW;
        end else begin
          case (opcode)
            OP_JMP: begin
              sel_next   = 1'b1;
              loc_next   = target;
              next_state = ST_SHADOW;
            end
            OP_JZ, OP_JNZ, OP_JC, OP_JNC: begin
              if ((opcode == OP_JZ  &&  flag_z) ||
                  (opcode == OP_JNZ && !flag_z) ||
                  (opcode == OP_JC  &&  flag_c) ||
                  (opcode == OP_JNC && !flag_c)) begin
                sel_next   = 1'b1;
                loc_next   = target;
                next_state = ST_SHADOW;
              end
            end
`ifdef JCU_CALL_RET_EN
            OP_CALL: begin
              // A full stack loses the return address but the call still goes.
              push_req   = 1'b1;
              push_data  = current_address + 1'b1;
              err_set    = stk_full;
              sel_next   = 1'b1;
              loc_next   = target;
              next_state = ST_SHADOW;
            end
            OP_RET: begin
              pop_req = 1'b1;
              if (stk_empty) begin
                err_set = 1'b1;
              end else begin
                sel_next   = 1'b1;
                loc_next   = stack_top;
                next_state = ST_SHADOW;
              end
            end
`endif
            OP_RETI: begin
              // Interrupts are re-enabled even when there is nothing to return to.
              pop_req = 1'b1;
              ie_next = 1'b1;
              if (stk_empty) begin
                err_set = 1'b1;
              end else begin
                sel_next   = 1'b1;
                loc_next   = stack_top;
                next_state = ST_SHADOW;
              end
            end
            default: ;
          endcase
        end
      end
      ST_SHADOW: begin
        // Wrong-path instruction squashed; a pending interrupt waits for RUN.
        next_state = ST_RUN;
      end
      default: next_state = ST_RUN;
    endcase
  end

  // Control state, registered outputs and stack pointer.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_RUN;
      pc_mux_sel <= 1'b0;
      jmp_loc    <= '0;
      int_ack    <= 1'b0;
      stk_err    <= 1'b0;
      ie         <= 1'b1;
      sp         <= '0;
    end else begin
      state      <= next_state;
      pc_mux_sel <= sel_next;
      jmp_loc    <= loc_next;
      int_ack    <= ack_next;
      stk_err    <= stk_err | err_set;
      ie         <= ie_next;
      if (do_push) begin
        sp <= sp + 1'b1;
      end else if (do_pop) begin
        sp <= sp - 1'b1;
      end
    end
  end

  // Return-address storage.
  // NOTE: the array itself is not reset; clearing sp makes every entry
  // unreachable, and no read happens without a prior write.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack_mem[sp[PTR_W-1:0]] <= push_data;
    end
  end

endmodule

// File: tb/tb_jump_control_unit_p.sv
// Directed bench for jump_control_unit_p: a vector table for single-cycle
// decisions plus hand-written reset, interrupt and stack sequences.
module tb_jump_control_unit_p;

  logic        clk;
  logic        reset;
  logic [19:0] ins;
  logic        interrupt;
  logic [7:0]  current_address;
  logic [3:0]  flag_ex;
  logic        pc_mux_sel;
  logic [7:0]  jmp_loc;
  logic        int_ack;
  logic        stk_err;

  int checks   = 0;
  int failures = 0;

  jump_control_unit_p dut (
    .clk             (clk),
    .reset           (reset),
    .ins             (ins),
    .interrupt       (interrupt),
    .current_address (current_address),
    .flag_ex         (flag_ex),
    .pc_mux_sel      (pc_mux_sel),
    .jmp_loc         (jmp_loc),
    .int_ack         (int_ack),
    .stk_err         (stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] ins;
    logic [3:0]  flag;
    logic        intr;
    logic [7:0]  addr;
    logic        sel;
    logic [7:0]  loc;
    logic        ack;
    logic        err;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present inputs, take one rising edge, settle past it.
  task automatic step(input logic [19:0] i, input logic [3:0] f, input logic irq,
                      input logic [7:0] a);
    ins             = i;
    flag_ex         = f;
    interrupt       = irq;
    current_address = a;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic sel, input logic [7:0] loc,
                           input logic ack, input logic err);
    check({tag, ".pc_mux_sel"}, 32'(pc_mux_sel), 32'(sel));
    check({tag, ".jmp_loc"},    32'(jmp_loc),    32'(loc));
    check({tag, ".int_ack"},    32'(int_ack),    32'(ack));
    check({tag, ".stk_err"},    32'(stk_err),    32'(err));
  endtask

  // Assert reset between edges, confirm outputs clear at once, hold 200, release
  // away from an edge.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_out({tag, ".async"}, 1'b0, 8'h00, 1'b0, 1'b0);
    #200;
    check_out({tag, ".held"}, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            ins       flag  irq  addr   sel  loc    ack  err
    vecs[0]  = '{20'h00000, 4'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{20'hC0008, 4'h0, 1'b0, 8'h00, 1'b1, 8'h08, 1'b0, 1'b0}; // JMP
    vecs[2]  = '{20'hC0033, 4'h0, 1'b0, 8'h00, 1'b0, 8'h08, 1'b0, 1'b0}; // shadow
    vecs[3]  = '{20'h00000, 4'h0, 1'b0, 8'h00, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[4]  = '{20'hE0010, 4'h8, 1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0}; // JZ taken
    vecs[5]  = '{20'h00000, 4'h0, 1'b0, 8'h00, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[6]  = '{20'hE0020, 4'h0, 1'b0, 8'h00, 1'b0, 8'h10, 1'b0, 1'b0}; // JZ not
    vecs[7]  = '{20'hE8030, 4'h0, 1'b0, 8'h00, 1'b1, 8'h30, 1'b0, 1'b0}; // JNZ taken
    vecs[8]  = '{20'h00000, 4'h0, 1'b0, 8'h00, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[9]  = '{20'hE8040, 4'h8, 1'b0, 8'h00, 1'b0, 8'h30, 1'b0, 1'b0}; // JNZ not
    vecs[10] = '{20'hF0050, 4'h4, 1'b0, 8'h00, 1'b1, 8'h50, 1'b0, 1'b0}; // JC taken
    vecs[11] = '{20'h00000, 4'h0, 1'b0, 8'h00, 1'b0, 8'h50, 1'b0, 1'b0};
    vecs[12] = '{20'hF0060, 4'h0, 1'b0, 8'h00, 1'b0, 8'h50, 1'b0, 1'b0}; // JC not
    vecs[13] = '{20'hF8070, 4'h0, 1'b0, 8'h00, 1'b1, 8'h70, 1'b0, 1'b0}; // JNC taken
    vecs[14] = '{20'h00000, 4'h0, 1'b0, 8'h00, 1'b0, 8'h70, 1'b0, 1'b0};
    vecs[15] = '{20'hF8071, 4'h4, 1'b0, 8'h00, 1'b0, 8'h70, 1'b0, 1'b0}; // JNC not
    vecs[16] = '{20'hC0008, 4'h0, 1'b1, 8'h04, 1'b1, 8'hF0, 1'b1, 1'b0}; // irq beats JMP
    vecs[17] = '{20'h00000, 4'h0, 1'b1, 8'h04, 1'b0, 8'hF0, 1'b0, 1'b0}; // shadow
    vecs[18] = '{20'h00000, 4'h0, 1'b1, 8'h05, 1'b0, 8'hF0, 1'b0, 1'b0}; // ie=0 pending
    vecs[19] = '{20'h80000, 4'h0, 1'b0, 8'h06, 1'b1, 8'h04, 1'b0, 1'b0}; // RETI
    vecs[20] = '{20'h00000, 4'h0, 1'b1, 8'h07, 1'b0, 8'h04, 1'b0, 1'b0}; // pending in shadow
    vecs[21] = '{20'hC0055, 4'h0, 1'b1, 8'h09, 1'b1, 8'hF0, 1'b1, 1'b0}; // serviced in RUN
    vecs[22] = '{20'h00000, 4'h0, 1'b0, 8'h00, 1'b0, 8'hF0, 1'b0, 1'b0};
    vecs[23] = '{20'h80000, 4'h0, 1'b0, 8'h00, 1'b1, 8'h09, 1'b0, 1'b0}; // RETI
    vecs[24] = '{20'h00000, 4'h0, 1'b0, 8'h00, 1'b0, 8'h09, 1'b0, 1'b0};
    vecs[25] = '{20'h80000, 4'h0, 1'b0, 8'h00, 1'b0, 8'h09, 1'b0, 1'b1}; // underflow
    vecs[26] = '{20'h00000, 4'h0, 1'b0, 8'h00, 1'b0, 8'h09, 1'b0, 1'b1}; // sticky

    reset           = 1'b0;
    ins             = '0;
    interrupt       = 1'b0;
    current_address = '0;
    flag_ex         = '0;
    #23;
    check_out("por", 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].ins, vecs[i].flag, vecs[i].intr, vecs[i].addr);
      check_out($sformatf("vec%0d", i), vecs[i].sel, vecs[i].loc, vecs[i].ack, vecs[i].err);
    end

    // Reset in the middle of a redirect; first decision on first edge after release.
    step(20'hC0022, 4'h0, 1'b0, 8'h00);
    check_out("pre_rst_jmp", 1'b1, 8'h22, 1'b0, 1'b1);
    pulse_reset("rst_shadow");
    step(20'hC0044, 4'h0, 1'b0, 8'h00);
    check_out("post_rst_jmp", 1'b1, 8'h44, 1'b0, 1'b0);
    step(20'h00000, 4'h0, 1'b0, 8'h00);
    check_out("post_rst_shadow", 1'b0, 8'h44, 1'b0, 1'b0);

    // Reset during interrupt entry discards the pushed address and restores ie.
    step(20'h00000, 4'h0, 1'b1, 8'h12);
    check_out("irq_entry", 1'b1, 8'hF0, 1'b1, 1'b0);
    pulse_reset("rst_irq");
    step(20'h00000, 4'h0, 1'b1, 8'h33);
    check_out("irq_after_rst", 1'b1, 8'hF0, 1'b1, 1'b0);
    step(20'h00000, 4'h0, 1'b0, 8'h00);
    step(20'h80000, 4'h0, 1'b0, 8'h00);
    check_out("reti_33", 1'b1, 8'h33, 1'b0, 1'b0);
    step(20'h00000, 4'h0, 1'b0, 8'h00);
    step(20'h80000, 4'h0, 1'b0, 8'h00);
    check_out("reti_discarded", 1'b0, 8'h33, 1'b0, 1'b1);

    pulse_reset("rst_stack");
`ifdef JCU_CALL_RET_EN
    // Five CALLs at 0x20 into a 4-deep stack, then five RETs.
    for (int i = 0; i < 5; i++) begin
      step(20'hD0040 | 20'(i), 4'h0, 1'b0, 8'h20);
      check_out($sformatf("call%0d", i), 1'b1, 8'h40 + 8'(i), 1'b0, (i == 4));
      step(20'h00000, 4'h0, 1'b0, 8'h20);
    end
    for (int i = 0; i < 4; i++) begin
      step(20'hD8000, 4'h0, 1'b0, 8'h50);
      check_out($sformatf("ret%0d", i), 1'b1, 8'h21, 1'b0, 1'b1);
      step(20'h00000, 4'h0, 1'b0, 8'h50);
    end
    step(20'hD8000, 4'h0, 1'b0, 8'h50);
    check_out("ret_underflow", 1'b0, 8'h21, 1'b0, 1'b1);
`else
    // CALL and RET decode as NOP in this build.
    step(20'hD0012, 4'h0, 1'b0, 8'h20);
    check_out("call_nop", 1'b0, 8'h00, 1'b0, 1'b0);
    step(20'hD8000, 4'h0, 1'b0, 8'h20);
    check_out("ret_nop", 1'b0, 8'h00, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jump_control_unit_p.md
JUMP_CONTROL_UNIT_P -- requirements
Module: jump_control_unit_p

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: program address width.
REQ-002 SHALL have parameter INS_W, default 20: instruction width, minimum ADDR_W+5.
REQ-003 SHALL have parameter STK_DEPTH, default 4: return-stack entries, power of two, minimum 2.
REQ-004 SHALL have parameter ISR_VEC, default ADDR_W'hF0: interrupt service entry address.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port ins, input, INS_W: instruction in execute stage; opcode = ins[INS_W-1:INS_W-5], target = ins[ADDR_W-1:0].
REQ-008 SHALL have port interrupt, input, 1: level interrupt request.
REQ-009 SHALL have port current_address, input, ADDR_W: address of ins.
REQ-010 SHALL have port flag_ex, input, 4: {Z,C,V,N} from execute stage.
REQ-011 SHALL have port pc_mux_sel, output, 1: 1 selects jmp_loc as next PC.
REQ-012 SHALL have port jmp_loc, output, ADDR_W: redirect address.
REQ-013 SHALL have port int_ack, output, 1: one-cycle pulse on interrupt entry.
REQ-014 SHALL have port stk_err, output, 1: sticky overflow/underflow flag.

Function
REQ-015 Opcodes SHALL be: 11000 JMP, 11100 JZ (Z=1), 11101 JNZ (Z=0), 11110 JC (C=1), 11111 JNC (C=0), 11010 CALL, 11011 RET, 10000 RETI; all others NOP.
REQ-016 Decision SHALL be registered: ins/flag_ex sampled at edge N drive pc_mux_sel=1 and jmp_loc for exactly cycle N+1; otherwise pc_mux_sel=0, jmp_loc holds last value.
REQ-017 Taken JMP/Jcc SHALL set jmp_loc=target; untaken Jcc SHALL leave pc_mux_sel=0.
REQ-018 CALL SHALL push (current_address+1) mod 2^ADDR_W and redirect to target.
REQ-019 RET and RETI SHALL pop the top entry into jmp_loc and redirect; RETI additionally sets interrupt-enable ie=1.
REQ-020 FSM SHALL have states RUN and SHADOW; any redirect moves RUN->SHADOW; SHADOW->RUN unconditionally next edge; ins is ignored (treated as NOP) while in SHADOW.
REQ-021 In RUN with interrupt=1 and ie=1, interrupt SHALL take priority over ins: push current_address (unexecuted instruction), jmp_loc=ISR_VEC, pc_mux_sel=1, int_ack=1, ie=0, enter SHADOW.
REQ-022 Interrupt asserted while ie=0 or in SHADOW SHALL remain pending (level) and be serviced at the first eligible RUN edge.
REQ-023 Push with stack full SHALL not write, SHALL set stk_err, and SHALL still redirect (CALL to target, interrupt to ISR_VEC).
REQ-024 Pop with stack empty SHALL not redirect, SHALL set stk_err; RETI still sets ie=1.
REQ-025 Stack pointer SHALL be log2(STK_DEPTH)+1 bits, full at count STK_DEPTH, no wrap.

Reset
REQ-026 reset=0 SHALL immediately force pc_mux_sel=0, jmp_loc=0, int_ack=0, stk_err=0, ie=1, stack count 0, state RUN.
REQ-027 Reset asserted mid-SHADOW or mid-interrupt-entry SHALL discard the redirect and all stack contents.
REQ-028 First decision after reset release SHALL occur on the first rising edge with reset=1.

Configuration
REQ-029 Macro JCU_CALL_RET_EN SHALL compile in CALL and RET; without it those opcodes decode as NOP and the stack serves interrupts/RETI only.

Verification
REQ-030 Reset pulse low 200 ns mid-run -> all outputs 0, ie=1, stack empty.
REQ-031 ins=20'hC0008 in RUN -> next cycle pc_mux_sel=1, jmp_loc=8'h08; following ins ignored; then pc_mux_sel=0.
REQ-032 flag_ex=4'h8, ins=20'hE0010 (JZ) -> redirect to 8'h10; flag_ex=4'h0 same ins -> pc_mux_sel stays 0.
REQ-033 interrupt=1, current_address=8'h04, ins=JMP -> jmp_loc=8'hF0, int_ack pulse, JMP dropped; RETI (20'h80000) -> jmp_loc=8'h04.
REQ-034 With JCU_CALL_RET_EN: five CALLs at address 8'h20 (STK_DEPTH=4) -> fifth sets stk_err, still redirects; four RETs return 8'h21; fifth RET no redirect.
